// File: rtl/hvac_zone_ctrl.sv
// hvac_zone_ctrl -- single-zone heat/cool controller with hysteresis and
// a minimum dwell time in every state.
//
// State | Meaning
// ------+----------------------------------------------------------
// IDLE  | neither heater nor cooler on; waits for a threshold crossing
// HEAT  | heater on until temperature climbs back to COMFORT
// COOL  | cooler on until temperature falls back to COMFORT
// FAULT | run-time limit hit; held until mode OFF or reset
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   mode         00 OFF, 01 AUTO, 10 HEAT_ONLY, 11 COOL_ONLY
//   temperature  unsigned measured temperature, WIDTH bits
//   heating      heater on   (state == HEAT)
//   cooling      cooler on   (state == COOL)
//   state        00 IDLE, 01 HEAT, 10 COOL, 11 FAULT
//   fault        run-time fault flag (state == FAULT)
//
// Build option
//   FAULT_DETECT_EN  when defined, a run-time counter moves HEAT/COOL into
//                    FAULT after MAX_RUN cycles without an exit. When not
//                    defined, there is no run counter and fault is tied to 0.
module hvac_zone_ctrl #(
  parameter int WIDTH       = 5,
  parameter int LOW_THRESH  = 18,
  parameter int COMFORT     = 20,
  parameter int HIGH_THRESH = 22,
  parameter int MIN_DWELL   = 2,
  parameter int MAX_RUN     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] temperature,
  output logic             heating,
  output logic             cooling,
  output logic [1:0]       state,
  output logic             fault
);

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_AUTO = 2'b01;
  localparam logic [1:0] MODE_HEAT = 2'b10;
  localparam logic [1:0] MODE_COOL = 2'b11;

  localparam int DW = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);
  localparam logic [DW-1:0]    DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [WIDTH-1:0] LOW_T     = WIDTH'(LOW_THRESH);
  localparam logic [WIDTH-1:0] COMFORT_T = WIDTH'(COMFORT);
  localparam logic [WIDTH-1:0] HIGH_T    = WIDTH'(HIGH_THRESH);

  // Threshold ordering and run limit are configuration errors, caught at elaboration.
  if (!(LOW_THRESH < COMFORT && COMFORT < HIGH_THRESH)) begin : g_bad_thresh
    $error("hvac_zone_ctrl: thresholds must satisfy LOW_THRESH < COMFORT < HIGH_THRESH");
  end
  if (MAX_RUN < 2) begin : g_bad_run
    $error("hvac_zone_ctrl: MAX_RUN must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HEAT  = 2'b01,
    ST_COOL  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            dwell_ok;
  logic            forced_idle;

`ifdef FAULT_DETECT_EN
  localparam int RW = (MAX_RUN < 2) ? 1 : $clog2(MAX_RUN);
  localparam logic [RW-1:0] RUN_LAST = RW'(MAX_RUN - 1);
  logic [RW-1:0]   run_q, run_d;
`endif

  always_comb begin
    state_d  = state_q;
    dwell_ok = (dwell_q == DWELL_MAX);
    // Mode-driven exits bypass dwell and take priority over everything else.
    forced_idle = (mode == MODE_OFF) ||
                  (state_q == ST_COOL && mode == MODE_HEAT) ||
                  (state_q == ST_HEAT && mode == MODE_COOL);

    if (forced_idle) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dwell_ok && (mode == MODE_AUTO || mode == MODE_HEAT) && temperature <= LOW_T)
            state_d = ST_HEAT;
          else if (dwell_ok && (mode == MODE_AUTO || mode == MODE_COOL) && temperature >= HIGH_T)
            state_d = ST_COOL;
        end
        ST_HEAT: begin
          if (dwell_ok && temperature >= COMFORT_T)
            state_d = ST_IDLE;
`ifdef FAULT_DETECT_EN
          else if (run_q == RUN_LAST)
            state_d = ST_FAULT;
`endif
        end
        ST_COOL: begin
          if (dwell_ok && temperature <= COMFORT_T)
            state_d = ST_IDLE;
`ifdef FAULT_DETECT_EN
          else if (run_q == RUN_LAST)
            state_d = ST_FAULT;
`endif
        end
        default: state_d = state_q;
      endcase
    end

    // Dwell restarts on any state change and saturates once the hold is met.
    if (state_d != state_q)
      dwell_d = '0;
    else if (dwell_q != DWELL_MAX)
      dwell_d = dwell_q + 1'b1;
    else
      dwell_d = dwell_q;

`ifdef FAULT_DETECT_EN
    if (state_d != state_q)
      run_d = '0;
    else if (state_q == ST_HEAT || state_q == ST_COOL)
      run_d = run_q + 1'b1;
    else
      run_d = run_q;
`endif
  end

  // Dwell resets saturated so the first decision after reset is immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dwell_q <= DWELL_MAX;
`ifdef FAULT_DETECT_EN
      run_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
`ifdef FAULT_DETECT_EN
      run_q   <= run_d;
`endif
    end
  end

  assign state   = state_q;
  assign heating = (state_q == ST_HEAT);
  assign cooling = (state_q == ST_COOL);
`ifdef FAULT_DETECT_EN
  assign fault   = (state_q == ST_FAULT);
`else
  assign fault   = 1'b0;
`endif

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// Scoreboard bench for hvac_zone_ctrl: a default-parameter instance and a
// WIDTH=8 instance driven in lockstep, checked against a cycle-age model.
module tb_hvac_zone_ctrl;

  localparam int MIN_DWELL = 2;
  localparam int MAX_RUN   = 16;
  localparam int IDLE = 0, HEAT = 1, COOL = 2, FLT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [4:0] temp5 = '0;
  logic [7:0] temp8 = '0;

  logic       heat5, cool5, fault5;
  logic [1:0] state5;
  logic       heat8, cool8, fault8;
  logic [1:0] state8;

  always #5 clk = ~clk;

  hvac_zone_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .temperature(temp5),
    .heating(heat5), .cooling(cool5), .state(state5), .fault(fault5)
  );

  hvac_zone_ctrl #(
    .WIDTH(8), .LOW_THRESH(100), .COMFORT(120), .HIGH_THRESH(140),
    .MIN_DWELL(MIN_DWELL), .MAX_RUN(MAX_RUN)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .temperature(temp8),
    .heating(heat8), .cooling(cool8), .state(state8), .fault(fault8)
  );

  // Model: state plus number of edges spent in it since entry.
  typedef struct { int st; int age; } mdl_t;
  typedef struct { int which; int st; } exp_t;

  mdl_t m5, m8;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st  = IDLE;
    r.age = MIN_DWELL;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t s, int md, int t, int lo, int co, int hi);
    mdl_t n;
    int   nxt;
    bit   held;
    nxt  = s.st;
    held = (s.age >= MIN_DWELL);
    if (md == 0 || (s.st == COOL && md == 2) || (s.st == HEAT && md == 3))
      nxt = IDLE;
    else if (s.st == IDLE) begin
      if (held && md != 3 && t <= lo)      nxt = HEAT;
      else if (held && md != 2 && t >= hi) nxt = COOL;
    end else if (s.st == HEAT || s.st == COOL) begin
      if (held && ((s.st == HEAT && t >= co) || (s.st == COOL && t <= co)))
        nxt = IDLE;
`ifdef FAULT_DETECT_EN
      else if (s.age == MAX_RUN - 1)
        nxt = FLT;
`endif
    end
    n.st  = nxt;
    n.age = (nxt != s.st) ? 0 : s.age + 1;
    return n;
  endfunction

  function automatic logic [4:0] pack_exp(int st);
    logic [1:0] s2;
    s2 = 2'(st);
    return {s2, st == HEAT, st == COOL, st == FLT};
  endfunction

  task automatic chk(string name, logic [4:0] act, logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {state,heat,cool,fault}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUTs present a new state; compare what was predicted.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.which == 5)
          chk("dut5_step", {state5, heat5, cool5, fault5}, pack_exp(e.st));
        else
          chk("dut8_step", {state8, heat8, cool8, fault8}, pack_exp(e.st));
      end
    end
  end

  task automatic drive(int md, int t5, int t8);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 2'(md);
    temp5 = 5'(t5);
    temp8 = 8'(t8);
    m5 = mstep(m5, md, t5, 18, 20, 22);
    m8 = mstep(m8, md, t8, 100, 120, 140);
    e.which = 5; e.st = m5.st; sb_q.push_back(e);
    e.which = 8; e.st = m8.st; sb_q.push_back(e);
  endtask

  task automatic drive_n(int n, int md, int t5, int t8);
    for (int i = 0; i < n; i++) drive(md, t5, t8);
  endtask

  initial begin
    int md;
    int t5;
    int t8;
    m5 = mdl_reset();
    m8 = mdl_reset();

    #1;
    chk("reset5", {state5, heat5, cool5, fault5}, 5'b0);
    chk("reset8", {state8, heat8, cool8, fault8}, 5'b0);
    repeat (2) @(negedge clk);

    // AUTO: 21 then 18 -> HEAT; 20 after dwell -> IDLE. WIDTH=8 lane: 255 -> COOL.
    drive_n(3, 1, 21, 130);
    drive_n(4, 1, 18, 255);
    drive_n(3, 1, 20, 255);
    drive_n(4, 1, 20, 120);

    // AUTO: 23 -> COOL; 20 one edge after entry -> IDLE only once dwell is met.
    drive(1, 23, 0);
    drive_n(5, 1, 20, 0);

    // HEAT_ONLY ignores hot readings; COOL_ONLY while heating forces IDLE.
    drive_n(3, 2, 25, 255);
    drive_n(2, 2, 10, 50);
    drive(3, 10, 50);
    drive_n(2, 0, 10, 50);

    // Long HEAT at 10: run-time fault when enabled, then OFF clears it.
    drive_n(20, 1, 10, 0);
    drive_n(2, 3, 10, 0);
    drive_n(20, 1, 10, 0);
    drive_n(2, 0, 10, 0);

    // Extremes of the temperature range.
    drive_n(4, 1, 31, 255);
    drive_n(4, 1, 0, 0);
    drive_n(4, 1, 31, 255);

    // Reset mid-cycle while cooling: outputs clear before the next edge.
    drive_n(4, 1, 25, 200);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst5", {state5, heat5, cool5, fault5}, 5'b0);
    chk("async_rst8", {state8, heat8, cool8, fault8}, 5'b0);
    m5 = mdl_reset();
    m8 = mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("held_rst5", {state5, heat5, cool5, fault5}, 5'b0);
    drive(1, 15, 90);
    drive_n(3, 1, 15, 90);

    // Randomized traffic around the thresholds with occasional mode changes.
    md = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) md = $urandom_range(0, 3);
      else if ($urandom_range(0, 40) == 0) md = 1;
      t5 = $urandom_range(14, 26);
      if ($urandom_range(0, 19) == 0) t5 = ($urandom_range(0, 1) == 0) ? 0 : 31;
      t8 = $urandom_range(90, 150);
      if ($urandom_range(0, 19) == 0) t8 = ($urandom_range(0, 1) == 0) ? 0 : 255;
      drive(md, t5, t8);
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
